serial_nibble_sub: RTL and testbench

Multi-cycle wide subtractor that computes `a - b - bin` over a W-bit operand by processing one 4-bit nibble per clock, LSB first. The borrow is chained between cycles through a register. It sits directly upstream of, and wraps, the 4-bit nibble subtraction slice. It gives the datapath wide subtraction at the area cost of a single nibble slice, behind a start/busy/done handshake.

---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/nibble_sub.sv | 34 +++
 rtl/serial_nibble_sub.sv | 160 ++++++++++++++++
 tb/tb_serial_nibble_sub.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared constants and state type for the serial nibble subtractor
//
// Purpose: slice width and FSM state encoding shared by nibble_sub and serial_nibble_sub.
// No ports.

package serial_sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/nibble_sub.sv
// rtl/nibble_sub.sv - combinational 4-bit subtraction slice computing x - y - bi
//
// Purpose: one nibble of a ripple subtractor, reused every cycle by the serial wrapper.
// Ports:
//   x, y : 4-bit minuend / subtrahend nibbles
//   bi   : borrow into bit 0
//   d    : 4-bit difference
//   bo   : borrow out of bit 3
//   b3   : borrow into bit 3 (used for signed overflow of the top nibble)

module nibble_sub
    import serial_sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                bi,
    output logic [NIBBLE_W-1:0] d,
    output logic                bo,
    output logic                b3
);

    // One extra bit on each difference: it is set exactly when the result
    // went negative, i.e. when a borrow left that field.
    logic [NIBBLE_W:0]   full;
    logic [NIBBLE_W-1:0] low3;

    assign full = {1'b0, x} - {1'b0, y} - {{NIBBLE_W{1'b0}}, bi};
    assign low3 = {1'b0, x[2:0]} - {1'b0, y[2:0]} - {3'b000, bi};

    assign d  = full[NIBBLE_W-1:0];
    assign bo = full[NIBBLE_W];
    assign b3 = low3[3];

endmodule

// File: rtl/serial_nibble_sub.sv
// rtl/serial_nibble_sub.sv - multi-cycle W-bit subtractor, one nibble per clock, LSB first
//
// Purpose: computes diff = a - b - bin over W = 4*NIBBLES bits using a single
// nibble_sub slice, borrow chained through a register, start/busy/done handshake.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : request operation (honoured in IDLE and DONE only)
//   a, b     : W-bit minuend / subtrahend, captured on accepted start
//   bin      : borrow-in, captured on accepted start
//   busy     : high while nibbles are being processed
//   done     : one-cycle pulse, diff/bout (and ovf) valid
//   diff     : registered W-bit result
//   bout     : registered borrow-out of the MSB nibble
//   ovf      : registered two's-complement overflow (SERIAL_SUB_OVF_EN only)

module serial_nibble_sub
    import serial_sub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        bin,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLE_W*NIBBLES-1:0] diff,
    output logic                        bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic                        ovf
`endif
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int KW = $clog2(NIBBLES);
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    sub_state_t          state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [W-1:0]        a_sh_q, a_sh_d;
    logic [W-1:0]        b_sh_q, b_sh_d;
    logic [W-1:0]        res_q, res_d;
    logic                brw_q, brw_d;
    logic [W-1:0]        diff_q, diff_d;
    logic                bout_q, bout_d;

    logic [NIBBLE_W-1:0] nd;
    logic                nbo;
`ifdef SERIAL_SUB_OVF_EN
    logic                nb3;
    logic                ovf_q, ovf_d;
`endif

    nibble_sub u_slice (
        .x  (a_sh_q[NIBBLE_W-1:0]),
        .y  (b_sh_q[NIBBLE_W-1:0]),
        .bi (brw_q),
        .d  (nd),
        .bo (nbo),
`ifdef SERIAL_SUB_OVF_EN
        .b3 (nb3)
`else
        .b3 ()
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    k_d     = '0;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = bin;
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                // New nibble enters at the MSB end so after NIBBLES shifts
                // nibble 0 has reached the LSB position.
                res_d  = {nd, res_q[W-1:NIBBLE_W]};
                brw_d  = nbo;
                a_sh_d = a_sh_q >> NIBBLE_W;
                b_sh_d = b_sh_q >> NIBBLE_W;
                k_d    = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = DONE;
                    k_d     = '0;
                    // Publish straight from the slice so the last nibble
                    // does not need an extra cycle through res_q.
                    diff_d  = {nd, res_q[W-1:NIBBLE_W]};
                    bout_d  = nbo;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = nb3 ^ nbo;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_nibble_sub.sv
// tb/tb_serial_nibble_sub.sv - scoreboard testbench for serial_nibble_sub (NIBBLES=4)

module tb_serial_nibble_sub;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    serial_nibble_sub #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           n_checks  = 0;
    int           n_fail    = 0;
    int           cyc       = 0;
    int           busy_left = 0;
    logic [W-1:0] hold_diff = '0;
    logic         hold_bout = 1'b0;
    logic         hold_ovf  = 1'b0;

    function automatic exp_t ref_model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic bi, input int c);
        exp_t   e;
        longint ua, ub, r, sa, sb, sr;
        ua = longint'(av);
        ub = longint'(bv);
        r  = ua - ub - longint'(bi);
        sa = av[W-1] ? ua - (64'sd1 <<< W) : ua;
        sb = bv[W-1] ? ub - (64'sd1 <<< W) : ub;
        sr = sa - sb - longint'(bi);
        e.diff = r[W-1:0];
        e.bout = (ua < ub + longint'(bi));
        e.ovf  = (sr > (64'sd1 <<< (W-1)) - 1) || (sr < -(64'sd1 <<< (W-1)));
        e.cyc  = c;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Protocol model: a start is taken only when no operation is in flight;
    // an operation occupies N edges, then the following edge may take a new one.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            busy_left <= 0;
        end else begin
            cyc <= cyc + 1;
            if (busy_left > 0) begin
                busy_left <= busy_left - 1;
            end else if (start) begin
                q.push_back(ref_model(a, b, bin, cyc + 1));
                busy_left <= N;
            end
        end
    end

    // Monitor: compares whenever the DUT presents a result.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_diff = '0;
            hold_bout = 1'b0;
            hold_ovf  = 1'b0;
        end else begin
            chk("busy", 64'(busy), 64'(busy_left > 0));
            chk("busy_done_excl", 64'(busy & done), 64'd0);
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("diff", 64'(diff), 64'(e.diff));
                    chk("bout", 64'(bout), 64'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
                    chk("ovf", 64'(ovf), 64'(e.ovf));
                    hold_ovf = e.ovf;
`endif
                    chk("done_latency", 64'(cyc - e.cyc), 64'(N));
                    hold_diff = e.diff;
                    hold_bout = e.bout;
                end
            end else begin
                chk("hold_diff", 64'(diff), 64'(hold_diff));
                chk("hold_bout", 64'(bout), 64'(hold_bout));
`ifdef SERIAL_SUB_OVF_EN
                chk("hold_ovf", 64'(ovf), 64'(hold_ovf));
`endif
            end
            if (q.size() > 0 && cyc > q[0].cyc + N) begin
                chk("missed_done", 64'd0, 64'd1);
                void'(q.pop_front());
            end
        end
    end

    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        bin   = bi;
        @(negedge clk);
        start = 1'b0;
        repeat (N + 1) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_diff"}, 64'(diff), 64'd0);
        chk({tag, "_bout"}, 64'(bout), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
`endif
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        op(16'h0001, 16'h0001, 1'b0);
        op(16'h1000, 16'h0001, 1'b0);
        op(16'h00FE, 16'h0005, 1'b1);
        op(16'h0003, 16'h0004, 1'b1);
        op(16'h0000, 16'h0000, 1'b1);
        op(16'h8000, 16'h0001, 1'b0);
        op(16'h7FFF, 16'hFFFF, 1'b0);
        op(16'h0005, 16'h0003, 1'b0);

        // start re-pulsed during RUN with different operands
        @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'h0234; bin = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'h0001; bin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (N + 2) @(negedge clk);

        // start held high, operands changing every cycle
        @(negedge clk);
        start = 1'b1;
        repeat (22) begin
            a   = W'($urandom);
            b   = W'($urandom);
            bin = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (N + 3) @(negedge clk);

        // reset in the second RUN cycle
        @(negedge clk);
        start = 1'b1; a = 16'h4321; b = 16'h1111; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_zero("midrun_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (N + 2) @(negedge clk);

        op(16'h4321, 16'h1111, 1'b0);

        // random operations with random idle gaps
        repeat (30) begin
            op(W'($urandom), W'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (N + 3) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
